// File: rtl/seq_divider.sv
// seq_divider: sequential restoring shift-subtract divider.
// Divides an unsigned WIDTH-bit dividend (Din at Run) by a previously loaded
// divisor and produces one quotient bit per clock.
//
// Control handshake: Run and Ld_Divisor are debounced level strobes. A command
// is accepted only on an edge where the block is in IDLE. Run wins over
// Ld_Divisor on the same edge. After a division the block waits in DONE until
// Run drops, so each press starts exactly one operation.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] Din,
   input  logic             Ld_Divisor,
   input  logic             Run,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic [WIDTH-1:0] Divisor,
   output logic             Busy,
   output logic             Done,
   output logic             Div_By_Zero,
   output logic [1:0]       Dbg_State
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state, w_state_n;
   logic [WIDTH:0]   r_a, w_a_n;        // partial remainder, MSB is trial sign
   logic [WIDTH-1:0] r_q, w_q_n;        // dividend shifting into quotient
   logic [CW-1:0]    r_cnt, w_cnt_n;
   logic [WIDTH-1:0] r_quot, w_quot_n;
   logic [WIDTH-1:0] r_rem, w_rem_n;
   logic [WIDTH-1:0] r_div, w_div_n;
   logic             r_dbz, w_dbz_n;

   // Datapath for one restoring iteration.
   logic [WIDTH:0]   w_a_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_trial_neg;
   // The partial remainder never exceeds the divisor, so the stored sign bit
   // is always zero and drops out of the shifted pair.
   logic             w_unused_sign;

   assign w_a_shift     = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
   assign w_trial       = w_a_shift - {1'b0, r_div};
   assign w_trial_neg   = w_trial[WIDTH];
   assign w_unused_sign = r_a[WIDTH];

   // State and datapath registers; synchronous reset clears everything.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_q     <= '0;
         r_cnt   <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_div   <= '0;
         r_dbz   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_a     <= w_a_n;
         r_q     <= w_q_n;
         r_cnt   <= w_cnt_n;
         r_quot  <= w_quot_n;
         r_rem   <= w_rem_n;
         r_div   <= w_div_n;
         r_dbz   <= w_dbz_n;
      end
   end

   // Next-state and next-datapath logic; everything holds unless updated.
   always_comb begin
      w_state_n = r_state;
      w_a_n     = r_a;
      w_q_n     = r_q;
      w_cnt_n   = r_cnt;
      w_quot_n  = r_quot;
      w_rem_n   = r_rem;
      w_div_n   = r_div;
      w_dbz_n   = r_dbz;
      case (r_state)
         S_IDLE: begin
            if (Run) begin
               if (r_div != '0) begin
                  w_a_n     = '0;
                  w_q_n     = Din;
                  w_cnt_n   = '0;
                  w_dbz_n   = 1'b0;
                  w_state_n = S_CALC;
               end else begin
                  w_quot_n  = '1;
                  w_rem_n   = Din;
                  w_dbz_n   = 1'b1;
                  w_state_n = S_DONE;
               end
            end else if (Ld_Divisor) begin
               w_div_n = Din;
            end
         end
         S_CALC: begin
            w_a_n   = w_trial_neg ? w_a_shift : w_trial;
            w_q_n   = {r_q[WIDTH-2:0], ~w_trial_neg};
            w_cnt_n = r_cnt + CW'(1);
            // The final iteration lands straight in the visible result.
            if (r_cnt == LAST) begin
               w_quot_n  = w_q_n;
               w_rem_n   = w_a_n[WIDTH-1:0];
               w_state_n = S_DONE;
            end
         end
         S_DONE: begin
            if (!Run) w_state_n = S_IDLE;
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   assign Quotient    = r_quot;
   assign Remainder   = r_rem;
   assign Divisor     = r_div;
   assign Busy        = (r_state == S_CALC);
   assign Done        = (r_state == S_DONE);
   assign Div_By_Zero = r_dbz;
   assign Dbg_State   = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed-vector bench for seq_divider (WIDTH=8).
module tb_seq_divider;

   localparam int W = 8;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic         Clk;
   logic         Reset;
   logic [W-1:0] Din;
   logic         Ld_Divisor;
   logic         Run;
   logic [W-1:0] Quotient;
   logic [W-1:0] Remainder;
   logic [W-1:0] Divisor;
   logic         Busy;
   logic         Done;
   logic         Div_By_Zero;
   logic [1:0]   Dbg_State;

   int checks = 0;
   int errors = 0;

   seq_divider #(.WIDTH(W)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Din         (Din),
      .Ld_Divisor  (Ld_Divisor),
      .Run         (Run),
      .Quotient    (Quotient),
      .Remainder   (Remainder),
      .Divisor     (Divisor),
      .Busy        (Busy),
      .Done        (Done),
      .Div_By_Zero (Div_By_Zero),
      .Dbg_State   (Dbg_State)
   );

   // Clock and reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Driver: load the divisor from IDLE.
   task automatic load_divisor(input logic [W-1:0] d);
      Din = d;
      Ld_Divisor = 1'b1;
      tick();
      Ld_Divisor = 1'b0;
   endtask

   // Driver: one-edge Run press carrying the dividend.
   task automatic start_div(input logic [W-1:0] d);
      Din = d;
      Run = 1'b1;
      tick();
      Run = 1'b0;
   endtask

   // Bounded wait for Done; returns the number of edges waited.
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!Done && cycles < 40) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; Din = '0; Ld_Divisor = 1'b0; Run = 1'b0;
      tick(); tick();
      Reset = 1'b0;
      checks++;
      if ({Quotient, Remainder, Divisor, Busy, Done, Div_By_Zero, Dbg_State} !== '0) begin
         errors++;
         $display("FAIL reset: q=%h r=%h d=%h busy=%b done=%b dbz=%b st=%0d, want all 0",
                  Quotient, Remainder, Divisor, Busy, Done, Div_By_Zero, Dbg_State);
      end
   endtask

   task automatic test_basic();
      int n;
      load_divisor(8'd7);
      checks++;
      if (Divisor !== 8'd7) begin
         errors++; $display("FAIL basic_load: divisor=%0d want 7", Divisor);
      end
      start_div(8'd100);
      n = 0;
      for (int i = 0; i < 12 && Busy; i++) begin
         n++;
         tick();
      end
      checks++;
      if (n !== 8) begin
         errors++; $display("FAIL basic_busy_len: busy cycles=%0d want 8", n);
      end
      checks++;
      if (Done !== 1'b1 || Busy !== 1'b0 || Dbg_State !== ST_DONE) begin
         errors++; $display("FAIL basic_done: done=%b busy=%b st=%0d want 1 0 2", Done, Busy, Dbg_State);
      end
      checks++;
      if (Quotient !== 8'h0E || Remainder !== 8'd2 || Div_By_Zero !== 1'b0) begin
         errors++; $display("FAIL basic_result: q=%h r=%h dbz=%b want 0e 02 0", Quotient, Remainder, Div_By_Zero);
      end
      tick();
      checks++;
      if (Dbg_State !== ST_IDLE || Quotient !== 8'h0E) begin
         errors++; $display("FAIL basic_idle: st=%0d q=%h want 0 0e", Dbg_State, Quotient);
      end
   endtask

   task automatic test_extremes();
      int n;
      load_divisor(8'd1);
      start_div(8'd255);
      wait_done(n);
      checks++;
      if (n !== 8 || Quotient !== 8'hFF || Remainder !== 8'h00) begin
         errors++; $display("FAIL ext_255_1: wait=%0d q=%h r=%h want 8 ff 00", n, Quotient, Remainder);
      end
      tick();
      load_divisor(8'hFF);
      start_div(8'hFF);
      wait_done(n);
      checks++;
      if (n !== 8 || Quotient !== 8'h01 || Remainder !== 8'h00) begin
         errors++; $display("FAIL ext_255_255: wait=%0d q=%h r=%h want 8 01 00", n, Quotient, Remainder);
      end
      tick();
   endtask

   task automatic test_hold_prev();
      int bad;
      load_divisor(8'd9);
      start_div(8'd5);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (Busy !== 1'b1 || Quotient !== 8'h01 || Remainder !== 8'h00) bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL hold_prev: %0d CALC cycles showed q/r other than 01/00", bad);
      end
      checks++;
      if (Done !== 1'b1 || Quotient !== 8'h00 || Remainder !== 8'h05) begin
         errors++; $display("FAIL div_gt_dividend: done=%b q=%h r=%h want 1 00 05", Done, Quotient, Remainder);
      end
      tick();
   endtask

   task automatic test_div_zero();
      int n;
      load_divisor(8'd0);
      start_div(8'd200);
      checks++;
      if (Done !== 1'b1 || Busy !== 1'b0 || Quotient !== 8'hFF || Remainder !== 8'hC8 || Div_By_Zero !== 1'b1) begin
         errors++; $display("FAIL dbz: done=%b busy=%b q=%h r=%h dbz=%b want 1 0 ff c8 1",
                            Done, Busy, Quotient, Remainder, Div_By_Zero);
      end
      tick();
      load_divisor(8'd3);
      start_div(8'd10);
      checks++;
      if (Div_By_Zero !== 1'b0 || Busy !== 1'b1) begin
         errors++; $display("FAIL dbz_clear: dbz=%b busy=%b want 0 1", Div_By_Zero, Busy);
      end
      wait_done(n);
      checks++;
      if (n !== 8 || Quotient !== 8'd3 || Remainder !== 8'd1 || Div_By_Zero !== 1'b0) begin
         errors++; $display("FAIL after_dbz: wait=%0d q=%h r=%h dbz=%b want 8 03 01 0", n, Quotient, Remainder, Div_By_Zero);
      end
      tick();
   endtask

   task automatic test_priority();
      int n;
      load_divisor(8'd4);
      Din = 8'd20;
      Run = 1'b1;
      Ld_Divisor = 1'b1;
      tick();
      Run = 1'b0;
      Ld_Divisor = 1'b0;
      checks++;
      if (Divisor !== 8'd4 || Busy !== 1'b1) begin
         errors++; $display("FAIL prio_run: divisor=%0d busy=%b want 4 1", Divisor, Busy);
      end
      wait_done(n);
      checks++;
      if (Quotient !== 8'd5 || Remainder !== 8'd0) begin
         errors++; $display("FAIL prio_result: q=%h r=%h want 05 00", Quotient, Remainder);
      end
      tick();
   endtask

   task automatic test_hold_run();
      int busy_n;
      int done_n;
      load_divisor(8'd2);
      Din = 8'd50;
      Run = 1'b1;
      tick();
      busy_n = 0;
      done_n = 0;
      for (int i = 0; i < 30; i++) begin
         if (Busy) busy_n++;
         if (Done) done_n++;
         if (i == 2) begin
            Din = 8'd5;
            Ld_Divisor = 1'b1;
         end else begin
            Ld_Divisor = 1'b0;
         end
         tick();
      end
      Ld_Divisor = 1'b0;
      checks++;
      if (busy_n !== 8 || done_n !== 22) begin
         errors++; $display("FAIL hold_run_once: busy=%0d done=%0d want 8 22", busy_n, done_n);
      end
      checks++;
      if (Dbg_State !== ST_DONE || Divisor !== 8'd2) begin
         errors++; $display("FAIL hold_run_state: st=%0d divisor=%0d want 2 2", Dbg_State, Divisor);
      end
      checks++;
      if (Quotient !== 8'd25 || Remainder !== 8'd0) begin
         errors++; $display("FAIL hold_run_result: q=%h r=%h want 19 00", Quotient, Remainder);
      end
      Run = 1'b0;
      tick();
      checks++;
      if (Dbg_State !== ST_IDLE) begin
         errors++; $display("FAIL hold_run_release: st=%0d want 0", Dbg_State);
      end
   endtask

   task automatic test_reset_mid();
      load_divisor(8'd6);
      start_div(8'd100);
      tick(); tick(); tick();
      checks++;
      if (Dbg_State !== ST_CALC) begin
         errors++; $display("FAIL mid_calc: st=%0d want 1", Dbg_State);
      end
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      checks++;
      if ({Quotient, Remainder, Divisor, Busy, Done, Div_By_Zero, Dbg_State} !== '0) begin
         errors++;
         $display("FAIL reset_mid: q=%h r=%h d=%h busy=%b done=%b dbz=%b st=%0d, want all 0",
                  Quotient, Remainder, Divisor, Busy, Done, Div_By_Zero, Dbg_State);
      end
      start_div(8'd77);
      checks++;
      if (Done !== 1'b1 || Quotient !== 8'hFF || Remainder !== 8'h4D || Div_By_Zero !== 1'b1) begin
         errors++; $display("FAIL reset_then_dbz: done=%b q=%h r=%h dbz=%b want 1 ff 4d 1",
                            Done, Quotient, Remainder, Div_By_Zero);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_hold_prev();
      test_div_zero();
      test_priority();
      test_hold_run();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
